dm_cache_ctrl: RTL and testbench

//  Sequencing controller for the direct-mapped byte cache. Accepts byte-read requests and does tag lookup.
//  On a miss it bursts the whole block from backing memory over the active-low cs/oe read port,

---
 rtl/dm_cache_ctrl.sv | 187 ++++++++++++++++++
 tb/tb_dm_cache_ctrl.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dm_cache_ctrl.sv
// dm_cache_ctrl: sequencing controller for a direct-mapped, read-only byte cache.
// It does tag lookup on accepted requests. On a miss it bursts the whole block from
// backing memory over an active-low cs/oe read port, then answers from the filled line.
// Optional feature macro: DM_CACHE_STATS_EN adds saturating hit/miss counters.
module dm_cache_ctrl #(
    parameter int ADDR_W   = 22,
    parameter int OFFSET_W = 2,
    parameter int INDEX_W  = 12,
    parameter int MEM_LAT  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic              flush,
    output logic              rsp_valid,
    output logic [7:0]        rsp_data,
    output logic              rsp_hit,
    output logic              mem_cs_n,
    output logic              mem_oe_n,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [7:0]        mem_data
`ifdef DM_CACHE_STATS_EN
    ,
    output logic [31:0]       hit_cnt,
    output logic [31:0]       miss_cnt
`endif
);

    localparam int TAG_W = ADDR_W - INDEX_W - OFFSET_W;
    localparam int LINES = 1 << INDEX_W;
    localparam int BYTES = LINES << OFFSET_W;
    localparam int LAT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(MEM_LAT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FLUSH,
        S_LOOKUP,
        S_REFILL,
        S_RESP
    } state_t;

    state_t state_q, state_d;

    logic [ADDR_W-1:0]   addr_q;
    logic [OFFSET_W-1:0] beat_q, beat_d;
    logic [LAT_W-1:0]    lat_q, lat_d;
    logic [LINES-1:0]    valid_q, valid_d;
    logic [7:0]          rsp_data_q, rsp_data_d;
    logic                rsp_hit_q, rsp_hit_d;

    logic [TAG_W-1:0]    tag_arr [0:LINES-1];
    logic [7:0]          data_arr [0:BYTES-1];

    logic [OFFSET_W-1:0] off;
    logic [INDEX_W-1:0]  idx;
    logic [TAG_W-1:0]    tag;
    logic                accept;
    logic                lookup_hit;
    logic                beat_done;
    logic                last_beat;

    assign off = addr_q[OFFSET_W-1:0];
    assign idx = addr_q[OFFSET_W +: INDEX_W];
    assign tag = addr_q[ADDR_W-1 -: TAG_W];

    // A flush in IDLE takes priority over a simultaneous request.
    assign accept     = (state_q == S_IDLE) && !flush && req_valid;
    assign lookup_hit = valid_q[idx] && (tag_arr[idx] == tag);
    // Memory data is sampled on the last cycle of each beat.
    assign beat_done  = (state_q == S_REFILL) && (lat_q == LAT_LAST);
    assign last_beat  = beat_done && (beat_q == '1);

    // State register; reset aborts any refill in progress.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (flush)          state_d = S_FLUSH;
                else if (req_valid) state_d = S_LOOKUP;
            end
            S_FLUSH:  state_d = S_IDLE;
            S_LOOKUP: state_d = lookup_hit ? S_RESP : S_REFILL;
            S_REFILL: if (last_beat) state_d = S_RESP;
            S_RESP:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Output decode; memory strobes are asserted only while refilling.
    always_comb begin
        req_ready = (state_q == S_IDLE) && !flush;
        rsp_valid = (state_q == S_RESP);
        mem_cs_n  = (state_q != S_REFILL);
        mem_oe_n  = (state_q != S_REFILL);
        mem_addr  = '0;
        if (state_q == S_REFILL) mem_addr = {tag, idx, beat_q};
    end

    // Next values for beat/latency counters, valid bits and the response registers.
    always_comb begin
        beat_d     = beat_q;
        lat_d      = '0;
        valid_d    = valid_q;
        rsp_data_d = rsp_data_q;
        rsp_hit_d  = rsp_hit_q;
        if (state_q == S_FLUSH) valid_d = '0;
        if (state_q == S_LOOKUP) begin
            beat_d = '0;
            if (lookup_hit) begin
                rsp_hit_d  = 1'b1;
                rsp_data_d = data_arr[{idx, off}];
            end
        end
        if (state_q == S_REFILL) begin
            lat_d = beat_done ? '0 : lat_q + 1'b1;
            if (beat_done) beat_d = beat_q + 1'b1;
        end
        // The requested byte is either arriving right now or was written by an earlier beat.
        if (last_beat) begin
            valid_d[idx] = 1'b1;
            rsp_hit_d    = 1'b0;
            rsp_data_d   = (off == '1) ? mem_data : data_arr[{idx, off}];
        end
    end

    // Control registers and response holding registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            beat_q     <= '0;
            lat_q      <= '0;
            valid_q    <= '0;
            rsp_data_q <= '0;
            rsp_hit_q  <= 1'b0;
        end else begin
            beat_q     <= beat_d;
            lat_q      <= lat_d;
            valid_q    <= valid_d;
            rsp_data_q <= rsp_data_d;
            rsp_hit_q  <= rsp_hit_d;
        end
    end

    // Unreset storage: request address, line data and tags.
    always_ff @(posedge clk) begin
        if (accept) addr_q <= req_addr;
        if (beat_done) data_arr[{idx, beat_q}] <= mem_data;
        if (last_beat) tag_arr[idx] <= tag;
    end

    assign rsp_data = rsp_data_q;
    assign rsp_hit  = rsp_hit_q;

`ifdef DM_CACHE_STATS_EN
    logic [31:0] hit_cnt_q;
    logic [31:0] miss_cnt_q;

    // Saturating lookup statistics, cleared only by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else if (state_q == S_LOOKUP) begin
            if (lookup_hit) begin
                if (hit_cnt_q != 32'hFFFF_FFFF) hit_cnt_q <= hit_cnt_q + 32'd1;
            end else begin
                if (miss_cnt_q != 32'hFFFF_FFFF) miss_cnt_q <= miss_cnt_q + 32'd1;
            end
        end
    end

    assign hit_cnt  = hit_cnt_q;
    assign miss_cnt = miss_cnt_q;
`endif

endmodule

// File: tb/tb_dm_cache_ctrl.sv
// tb_dm_cache_ctrl: scoreboard bench for dm_cache_ctrl with a cache-level reference model.
// Memory model: byte at address A is A[7:0]^8'h5A. Define DM_CACHE_STATS_EN to cover the counters.
module tb_dm_cache_ctrl;

    localparam int ADDR_W   = 22;
    localparam int OFFSET_W = 2;
    localparam int INDEX_W  = 12;
    localparam int MEM_LAT  = 2;
    localparam int BEATS    = 1 << OFFSET_W;
    localparam int LINES    = 1 << INDEX_W;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              req_valid = 1'b0;
    logic              req_ready;
    logic [ADDR_W-1:0] req_addr = '0;
    logic              flush = 1'b0;
    logic              rsp_valid;
    logic [7:0]        rsp_data;
    logic              rsp_hit;
    logic              mem_cs_n;
    logic              mem_oe_n;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_data;
`ifdef DM_CACHE_STATS_EN
    logic [31:0]       hit_cnt;
    logic [31:0]       miss_cnt;
`endif

    dm_cache_ctrl #(
        .ADDR_W(ADDR_W), .OFFSET_W(OFFSET_W), .INDEX_W(INDEX_W), .MEM_LAT(MEM_LAT)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr), .flush(flush),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_hit(rsp_hit),
        .mem_cs_n(mem_cs_n), .mem_oe_n(mem_oe_n), .mem_addr(mem_addr), .mem_data(mem_data)
`ifdef DM_CACHE_STATS_EN
        , .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Backing memory: only drives meaningful data while selected.
    assign mem_data = (!mem_cs_n && !mem_oe_n) ? (mem_addr[7:0] ^ 8'h5A) : 8'h00;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [7:0] data;
        logic       hit;
        int         cyc;
    } exp_t;

    exp_t              exp_q[$];
    logic [ADDR_W-1:0] line_q[$];
    int                strobe_cnt = 0;
    int                n_vec = 0;
    int                n_err = 0;

    // Reference cache state
    bit                m_valid [0:LINES-1];
    logic [7:0]        m_tag   [0:LINES-1];
    int                m_hits = 0;
    int                m_misses = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string nm);
        n_vec++;
        n_err++;
        $display("FAIL %s (cycle %0d)", nm, cyc);
    endtask

    task automatic finish_run();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    endtask

    task automatic model_clear();
        for (int i = 0; i < LINES; i++) m_valid[i] = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_req_ready"}, {31'd0, req_ready}, 32'd1);
        chk({tag, "_rsp_valid"}, {31'd0, rsp_valid}, 32'd0);
        chk({tag, "_rsp_hit"},   {31'd0, rsp_hit},   32'd0);
        chk({tag, "_rsp_data"},  {24'd0, rsp_data},  32'd0);
        chk({tag, "_mem_cs_n"},  {31'd0, mem_cs_n},  32'd1);
        chk({tag, "_mem_oe_n"},  {31'd0, mem_oe_n},  32'd1);
        chk({tag, "_mem_addr"},  {10'd0, mem_addr},  32'd0);
    endtask

    // Returns shortly after a negedge at which the controller is ready; while busy it
    // throws random requests and flushes at the DUT, which must ignore them.
    task automatic wait_ready();
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            req_valid = 1'b0;
            flush = 1'b0;
            #1;
            if (req_ready) return;
            req_valid = 1'($urandom_range(0, 1));
            flush     = 1'($urandom_range(0, 1));
            req_addr  = ADDR_W'($urandom);
        end
        fail_now("ready_timeout");
        finish_run();
    endtask

    task automatic do_read(input logic [ADDR_W-1:0] a);
        exp_t e;
        logic [INDEX_W-1:0] ix;
        logic [7:0] tg;
        bit h;
        wait_ready();
        req_valid = 1'b1;
        req_addr  = a;
        ix = a[OFFSET_W +: INDEX_W];
        tg = a[ADDR_W-1 -: 8];
        h  = m_valid[ix] && (m_tag[ix] == tg);
        if (h) begin
            m_hits++;
        end else begin
            m_misses++;
            m_valid[ix] = 1'b1;
            m_tag[ix]   = tg;
            line_q.push_back({a[ADDR_W-1:OFFSET_W], {OFFSET_W{1'b0}}});
        end
        e.data = a[7:0] ^ 8'h5A;
        e.hit  = h;
        e.cyc  = cyc + (h ? 2 : 2 + BEATS * MEM_LAT);
        exp_q.push_back(e);
    endtask

    task automatic do_flush(input bit with_req);
        wait_ready();
        flush     = 1'b1;
        req_valid = with_req;
        req_addr  = ADDR_W'($urandom);
        #1;
        chk("flush_blocks_ready", {31'd0, req_ready}, 32'd0);
        model_clear();
        @(negedge clk);
        flush = 1'b0;
        req_valid = 1'b0;
        #1;
        chk("ready_low_in_flush", {31'd0, req_ready}, 32'd0);
    endtask

    task automatic drain();
        for (int k = 0; k < 40; k++) begin
            if (exp_q.size() == 0) return;
            @(negedge clk);
        end
        fail_now("response_timeout");
        finish_run();
    endtask

    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst) begin
                strobe_cnt = 0;
            end else begin
                if (!mem_cs_n) begin
                    chk("oe_with_cs", {31'd0, mem_oe_n}, 32'd0);
                    if (line_q.size() == 0) fail_now("unexpected_mem_strobe");
                    else chk("mem_addr", {10'd0, mem_addr}, 32'(line_q[0]) + 32'(strobe_cnt / MEM_LAT));
                    strobe_cnt++;
                end
                if (rsp_valid) begin
                    if (exp_q.size() == 0) begin
                        fail_now("unexpected_rsp");
                    end else begin
                        e = exp_q.pop_front();
                        chk("rsp_data", {24'd0, rsp_data}, {24'd0, e.data});
                        chk("rsp_hit", {31'd0, rsp_hit}, {31'd0, e.hit});
                        chk("rsp_cycle", cyc, e.cyc);
                        chk("strobe_cycles", strobe_cnt, e.hit ? 0 : BEATS * MEM_LAT);
                        if (!e.hit && line_q.size() != 0) void'(line_q.pop_front());
                    end
                    strobe_cnt = 0;
                end
            end
        end
    endtask

    initial begin
        logic [ADDR_W-1:0] a;
        int sel;
        bit hit_refill;
        model_clear();
        fork
            monitor();
        join_none

        // Reset state
        @(negedge clk);
        @(negedge clk);
        #1;
        check_reset_outputs("reset");
        @(negedge clk);
        rst = 1'b0;

        // Cold miss, hit in same line, conflict miss, hit, eviction miss
        do_read(22'd4);
        do_read(22'd5);
        do_read(22'd16388);
        do_read(22'd16391);
        do_read(22'd4);
        drain();
`ifdef DM_CACHE_STATS_EN
        chk("hit_cnt_directed", hit_cnt, 32'd2);
        chk("miss_cnt_directed", miss_cnt, 32'd3);
`endif

        // Flush wins over a simultaneous request
        do_read(22'd42);
        do_read(22'd43);
        do_flush(1'b1);
        do_read(22'd43);
        drain();

        // Reset during beat 2 of a refill
        do_read(22'd8);
        hit_refill = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            req_valid = 1'b0;
            if (!mem_cs_n && mem_addr == 22'd10) begin
                hit_refill = 1'b1;
                break;
            end
        end
        if (!hit_refill) begin
            fail_now("beat2_not_seen");
            finish_run();
        end
        rst = 1'b1;
        #1;
        check_reset_outputs("midrefill_reset");
        exp_q.delete();
        line_q.delete();
        model_clear();
        m_hits = 0;
        m_misses = 0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        do_read(22'd8);
        do_read(22'd9);
        drain();

        // Randomized traffic over a few contended indices
        for (int n = 0; n < 300; n++) begin
            sel = $urandom_range(0, 19);
            if (sel == 0) begin
                do_flush(1'($urandom_range(0, 1)));
            end else if (sel == 1) begin
                do_read(ADDR_W'($urandom));
            end else begin
                case ($urandom_range(0, 4))
                    0: a[OFFSET_W +: INDEX_W] = 12'd0;
                    1: a[OFFSET_W +: INDEX_W] = 12'd1;
                    2: a[OFFSET_W +: INDEX_W] = 12'd2;
                    3: a[OFFSET_W +: INDEX_W] = 12'd3;
                    default: a[OFFSET_W +: INDEX_W] = 12'hFFF;
                endcase
                a[ADDR_W-1 -: 8]     = 8'($urandom_range(0, 3));
                a[OFFSET_W-1:0]      = 2'($urandom_range(0, 3));
                do_read(a);
            end
        end
        drain();
        @(negedge clk);
        req_valid = 1'b0;
        flush = 1'b0;
`ifdef DM_CACHE_STATS_EN
        chk("hit_cnt_final", hit_cnt, 32'(m_hits));
        chk("miss_cnt_final", miss_cnt, 32'(m_misses));
`endif
        chk("scoreboard_empty", exp_q.size(), 0);
        repeat (3) @(negedge clk);
        finish_run();
    end

endmodule
